// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation ADC controller.
// Drives a WIDTH-bit trial code into a capacitive DAC and resolves one bit
// per bit-period (MSB first) from a synchronised comparator decision.
// Ports:
//   CLK      core clock
//   reset    asynchronous active-low reset
//   start    conversion request, sampled only when idle
//   abort    synchronous cancel of a conversion in progress
//   COMP_IN  asynchronous comparator output (1 = Vin >= Vdac(DAC_D))
//   SAMPLE   track/hold enable
//   DAC_D    trial code to the DAC; holds RESULT when idle
//   busy     conversion in progress
//   done     one-cycle pulse when RESULT is updated
//   valid    RESULT holds a completed conversion
//   RESULT   last completed conversion code
module sar_adc_ctrl #(
  parameter int unsigned WIDTH         = 10,
  parameter int unsigned SAMPLE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             COMP_IN,
  output logic             SAMPLE,
  output logic [WIDTH-1:0] DAC_D,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [WIDTH-1:0] RESULT
);

  localparam int unsigned T_BIT = 1 + SETTLE_CYCLES + SYNC_STAGES;
  localparam int unsigned CW    = 8;
  localparam int unsigned IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_BIT
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [WIDTH-1:0]       dac_q, dac_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   sample_q, sample_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   comp_s;
  logic [WIDTH-1:0]       bit_mask;
  logic [WIDTH-1:0]       decided;

  // Comparator synchroniser; runs continuously.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], COMP_IN};
    end
  end

  assign comp_s = sync_q[SYNC_STAGES-1];

  // State and output registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      dac_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      sample_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dac_d    = dac_q;
    result_d = result_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    sample_d = sample_q;
    bit_mask = WIDTH'(1) << idx_q;
    // Current bit is kept only if Vin >= Vdac(trial).
    decided  = comp_s ? dac_q : (dac_q & ~bit_mask);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SAMPLE;
          sample_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          state_d  = ST_IDLE;
          sample_d = 1'b0;
          busy_d   = 1'b0;
          dac_d    = result_q;
          cnt_d    = '0;
        end else if (cnt_q == CW'(SAMPLE_CYCLES - 1)) begin
          state_d  = ST_BIT;
          sample_d = 1'b0;
          idx_d    = IW'(WIDTH - 1);
          dac_d    = WIDTH'(1) << (WIDTH - 1);
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_BIT: begin
        if (abort) begin
          state_d  = ST_IDLE;
          sample_d = 1'b0;
          busy_d   = 1'b0;
          dac_d    = result_q;
          cnt_d    = '0;
        end else if (cnt_q == CW'(T_BIT - 1)) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d  = ST_IDLE;
            result_d = decided;
            dac_d    = decided;
            done_d   = 1'b1;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
          end else begin
            // Resolve bit i and raise trial bit i-1 on the same edge.
            idx_d = idx_q - IW'(1);
            dac_d = decided | (bit_mask >> 1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign SAMPLE = sample_q;
  assign DAC_D  = dac_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign valid  = valid_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: a combinational comparator model
// closes the loop; expected codes are queued on start and popped on done.
module tb_sar_adc_ctrl;

  localparam int unsigned W      = 10;
  localparam int unsigned SC     = 4;
  localparam int unsigned TB     = 4;
  localparam int unsigned TCONV  = SC + W * TB;
  localparam int unsigned TCONV6 = 1 + W * 4;

  logic         clk;
  logic         rst_n;
  logic         start, abort, comp;
  logic         sample, busy, done, valid;
  logic [W-1:0] dac_d, result;
  logic [W-1:0] vin;

  logic         start6, abort6, comp6;
  logic         sample6, busy6, done6, valid6;
  logic [W-1:0] dac_d6, result6;
  logic [W-1:0] vin6;

  int total = 0;
  int bad   = 0;
  logic prev_valid = 1'b0;
  logic [W-1:0] sb[$];

  sar_adc_ctrl u_dut (
    .CLK(clk), .reset(rst_n), .start(start), .abort(abort), .COMP_IN(comp),
    .SAMPLE(sample), .DAC_D(dac_d), .busy(busy), .done(done),
    .valid(valid), .RESULT(result)
  );

  sar_adc_ctrl #(.SAMPLE_CYCLES(1), .SETTLE_CYCLES(0), .SYNC_STAGES(3)) u_dut6 (
    .CLK(clk), .reset(rst_n), .start(start6), .abort(abort6), .COMP_IN(comp6),
    .SAMPLE(sample6), .DAC_D(dac_d6), .busy(busy6), .done(done6),
    .valid(valid6), .RESULT(result6)
  );

  assign comp  = (vin >= dac_d);
  assign comp6 = (vin6 >= dac_d6);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference SAR trial sequence for a given input level.
  function automatic void sar_seq(input logic [W-1:0] v, output logic [W-1:0] seq [W]);
    logic [W-1:0] code;
    logic [W-1:0] trial;
    code = '0;
    for (int k = 0; k < int'(W); k++) begin
      trial  = code | (W'(1) << (W - 1 - k));
      seq[k] = trial;
      if (v >= trial) code = trial;
    end
  endfunction

  // One full conversion on the default instance, checked cycle by cycle.
  task automatic run_conv(input logic [W-1:0] v);
    logic [W-1:0] seq [W];
    logic [W-1:0] exp_r;
    sar_seq(v, seq);
    vin   = v;
    start = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_sample", 32'(sample), 32'd1);
    for (int n = 1; n <= int'(TCONV); n++) begin
      @(negedge clk);
      if (n < int'(TCONV)) begin
        if (n >= int'(SC)) begin
          if ((n - int'(SC)) % int'(TB) == 0)
            chk($sformatf("dac_first_%0d", n), 32'(dac_d), 32'(seq[(n - int'(SC)) / int'(TB)]));
          if ((n - int'(SC)) % int'(TB) == int'(TB) - 1)
            chk($sformatf("dac_hold_%0d", n), 32'(dac_d), 32'(seq[(n - int'(SC)) / int'(TB)]));
        end
        if (n == int'(SC) - 1) chk("sample_hi", 32'(sample), 32'd1);
        if (n == int'(SC)) chk("sample_lo", 32'(sample), 32'd0);
        if (n == int'(TCONV) - 1) begin
          chk("pre_done", 32'(done), 32'd0);
          chk("pre_valid", 32'(valid), 32'(prev_valid));
          chk("pre_busy", 32'(busy), 32'd1);
        end
      end else begin
        exp_r = sb.pop_front();
        chk("done", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(valid), 32'd1);
        chk("result", 32'(result), 32'(exp_r));
        chk("idle_dac", 32'(dac_d), 32'(exp_r));
      end
    end
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
    prev_valid = 1'b1;
  endtask

  initial begin
    int cyc, last_done, ndone, tout;
    logic [W-1:0] exp_r;
    logic was_done;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; vin = '0;
    start6 = 1'b0; abort6 = 1'b0; vin6 = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_dac", 32'(dac_d), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: nominal conversion
    run_conv(10'h2A5);
    // 2: full-scale and zero
    run_conv(10'h3FF);
    run_conv(10'h000);

    // 3: start held high, back-to-back conversions
    vin = 10'h155;
    repeat (3) sb.push_back(10'h155);
    start = 1'b1;
    cyc = 0; last_done = -1; ndone = 0; was_done = 1'b0;
    tout = 0;
    while (ndone < 3) begin
      @(negedge clk);
      cyc++;
      if (was_done) chk("b2b_width", 32'(done), 32'd0);
      was_done = done;
      if (done) begin
        ndone++;
        exp_r = sb.pop_front();
        chk("b2b_result", 32'(result), 32'(exp_r));
        chk("b2b_busy", 32'(busy), 32'd0);
        if (last_done < 0) chk("b2b_first", 32'(cyc), 32'(TCONV + 1));
        else chk("b2b_gap", 32'(cyc - last_done), 32'(TCONV + 1));
        last_done = cyc;
        if (ndone == 3) start = 1'b0;
      end
      if (cyc > 400) begin
        chk("b2b_timeout", 32'd0, 32'd1);
        tout = 1;
        break;
      end
    end
    if (tout != 0) sb.delete();
    @(negedge clk);
    chk("b2b_stop", 32'(busy), 32'd0);

    // 4: abort mid-conversion keeps previous result
    run_conv(10'h123);
    vin   = 10'h0F0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'h123);
    chk("abort_dac", 32'(dac_d), 32'h123);
    chk("abort_valid", 32'(valid), 32'd1);
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_conv(10'h0F0);

    // 5: asynchronous reset mid-BIT
    vin   = 10'h2A5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sample", 32'(sample), 32'd0);
    chk("arst_dac", 32'(dac_d), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    prev_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_conv(10'h1E7);

    // 6: overridden timing parameters
    vin6   = 10'h3C3;
    start6 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start6 = 1'b0;
    repeat (int'(TCONV6) - 1) @(negedge clk);
    chk("p6_pre_done", 32'(done6), 32'd0);
    @(negedge clk);
    chk("p6_done", 32'(done6), 32'd1);
    chk("p6_result", 32'(result6), 32'h3C3);
    chk("p6_valid", 32'(valid6), 32'd1);
    @(negedge clk);
    chk("p6_width", 32'(done6), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
